// File: rtl/ex_muldiv_unit_pkg.sv
// Shared constants, encodings and helpers for the EX-stage multiply/divide unit.
package ex_muldiv_unit_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // Magnitude of a two's complement value; unsigned operands pass through.
  function automatic logic [WIDTH-1:0] md_abs(input logic [WIDTH-1:0] v,
                                               input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side request, MTHI/MTLO and HI/LO result signals of the mul/div unit.
interface ex_muldiv_unit_if;
  import ex_muldiv_unit_pkg::*;

  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] rs_data_i;
  logic [WIDTH-1:0] rt_data_i;
  logic             flush_i;
  logic             hi_we_i;
  logic             lo_we_i;
  logic [WIDTH-1:0] wdata_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, rs_data_i, rt_data_i, flush_i, hi_we_i, lo_we_i, wdata_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_data_i, rt_data_i, flush_i, hi_we_i, lo_we_i, wdata_i,
    output busy_o, done_o, hi_o, lo_o
  );

endinterface

// File: rtl/ex_muldiv_unit_md_datapath.sv
// Combinational single-iteration step (shift-add / restoring subtract) and
// the final sign-fix negators for the iterative mul/div unit.
module ex_muldiv_unit_md_datapath
  import ex_muldiv_unit_pkg::*;
(
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_hi_acc,
  input  logic [WIDTH-1:0] i_lo_acc,
  input  logic [WIDTH-1:0] i_opb,
  input  logic             i_res_neg,
  input  logic             i_rem_neg,
  output logic [WIDTH-1:0] o_step_hi_c,
  output logic [WIDTH-1:0] o_step_lo_c,
  output logic [WIDTH-1:0] o_fix_hi_c,
  output logic [WIDTH-1:0] o_fix_lo_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Multiply: add multiplicand when the current multiplier LSB is set, then shift right.
  assign w_add = {1'b0, i_hi_acc} + (i_lo_acc[0] ? {1'b0, i_opb} : (WIDTH+1)'(0));

  // Divide: the shifted partial remainder needs one extra bit before the compare.
  assign w_shift = {i_hi_acc, i_lo_acc[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, i_opb});
  assign w_sub   = w_shift[WIDTH-1:0] - i_opb;

  always_comb begin
    o_step_hi_c = '0;
    o_step_lo_c = '0;
    if (i_is_div) begin
      o_step_hi_c = w_ge ? w_sub : w_shift[WIDTH-1:0];
      o_step_lo_c = {i_lo_acc[WIDTH-2:0], w_ge};
    end else begin
      o_step_hi_c = w_add[WIDTH:1];
      o_step_lo_c = {w_add[0], i_lo_acc[WIDTH-1:1]};
    end
  end

  assign w_prod     = {i_hi_acc, i_lo_acc};
  assign w_prod_fix = i_res_neg ? (~w_prod + PW'(1)) : w_prod;
  assign w_quo_fix  = i_res_neg ? (~i_lo_acc + WIDTH'(1)) : i_lo_acc;
  assign w_rem_fix  = i_rem_neg ? (~i_hi_acc + WIDTH'(1)) : i_hi_acc;

  always_comb begin
    o_fix_hi_c = w_prod_fix[PW-1:WIDTH];
    o_fix_lo_c = w_prod_fix[WIDTH-1:0];
    if (i_is_div) begin
      o_fix_hi_c = w_rem_fix;
      o_fix_lo_c = w_quo_fix;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit: FSM, iteration counter, operand
// accumulators and the architectural HI/LO registers.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  ex_muldiv_unit_if.slave   bus
);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_fix;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi_acc;
  logic [WIDTH-1:0] r_lo_acc;
  logic [WIDTH-1:0] r_opb;
  logic             r_is_div;
  logic             r_res_neg;
  logic             r_rem_neg;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  md_op_e           w_op;
  logic             w_in_div;
  logic             w_in_signed;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_rs_mag;
  logic [WIDTH-1:0] w_rt_mag;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_op        = md_op_e'(bus.op_i);
  assign w_in_div    = (w_op == MD_DIV) || (w_op == MD_DIVU);
  assign w_in_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
  assign w_div_zero  = w_in_div && (bus.rt_data_i == '0);
  assign w_rs_mag    = md_abs(bus.rs_data_i, w_in_signed);
  assign w_rt_mag    = md_abs(bus.rt_data_i, w_in_signed);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Flush wins over everything, including a start presented in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          w_load      = 1'b1;
          w_state_nxt = w_div_zero ? FIX : CALC;
        end
      end
      CALC: begin
        if (bus.flush_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = FIX;
        end
      end
      FIX: begin
        w_state_nxt = IDLE;
        if (!bus.flush_i) w_fix = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Mul: lo holds the multiplier, opb the multiplicand. Div: lo holds the dividend, opb the divisor.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt     <= '0;
      r_hi_acc  <= '0;
      r_lo_acc  <= '0;
      r_opb     <= '0;
      r_is_div  <= 1'b0;
      r_res_neg <= 1'b0;
      r_rem_neg <= 1'b0;
    end else if (w_load) begin
      r_cnt    <= '0;
      r_is_div <= w_in_div;
      if (w_div_zero) begin
        r_hi_acc  <= bus.rs_data_i;
        r_lo_acc  <= '1;
        r_opb     <= '0;
        r_res_neg <= 1'b0;
        r_rem_neg <= 1'b0;
      end else begin
        r_hi_acc  <= '0;
        r_lo_acc  <= w_in_div ? w_rs_mag : w_rt_mag;
        r_opb     <= w_in_div ? w_rt_mag : w_rs_mag;
        r_res_neg <= w_in_signed && (bus.rs_data_i[WIDTH-1] ^ bus.rt_data_i[WIDTH-1]);
        r_rem_neg <= w_in_signed && w_in_div && bus.rs_data_i[WIDTH-1];
      end
    end else if (w_step) begin
      r_hi_acc <= w_step_hi;
      r_lo_acc <= w_step_lo;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  ex_muldiv_unit_md_datapath u_datapath (
    .i_is_div    (r_is_div),
    .i_hi_acc    (r_hi_acc),
    .i_lo_acc    (r_lo_acc),
    .i_opb       (r_opb),
    .i_res_neg   (r_res_neg),
    .i_rem_neg   (r_rem_neg),
    .o_step_hi_c (w_step_hi),
    .o_step_lo_c (w_step_lo),
    .o_fix_hi_c  (w_fix_hi),
    .o_fix_lo_c  (w_fix_lo)
  );

  // MTHI/MTLO land only in IDLE; an operation result later overwrites them.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (r_state == IDLE) begin
        if (bus.hi_we_i) r_hi <= bus.wdata_i;
        if (bus.lo_we_i) r_lo <= bus.wdata_i;
      end
      if (w_fix) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end
  end

  assign bus.busy_o = (r_state != IDLE);
  assign bus.done_o = r_done;
  assign bus.hi_o   = r_hi;
  assign bus.lo_o   = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit with hand-computed results.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ex_muldiv_unit_if bus ();

  ex_muldiv_unit u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.rs_data_i = rs;
    bus.rt_data_i = rt;
    @(negedge clk);
    bus.start_i   = 1'b0;
  endtask

  // Called at the negedge after the start edge; ends one cycle after done, with done checked low.
  task automatic wait_done(input string tag, output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!bus.done_o && lat < 100) begin
      if (bus.busy_o) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, 64'(bus.done_o), 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done_o), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    int bc;
    start_op(op, rs, rt);
    wait_done(tag, lat, bc);
    check({tag, "_hi"}, 64'(bus.hi_o), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo_o), 64'(exp_lo));
  endtask

  initial begin
    int lat;
    int bc;
    int nd;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.start_i   = 1'b0;
    bus.op_i      = 2'b00;
    bus.rs_data_i = '0;
    bus.rt_data_i = '0;
    bus.flush_i   = 1'b0;
    bus.hi_we_i   = 1'b0;
    bus.lo_we_i   = 1'b0;
    bus.wdata_i   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_hi", 64'(bus.hi_o), 64'd0);
    check("rst_lo", 64'(bus.lo_o), 64'd0);
    rst_n = 1'b1;

    // MULT -2 * 3 with latency and busy-length checks
    start_op(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done("mult", lat, bc);
    check("mult_latency", 64'(lat), 64'd33);
    check("mult_busy_cycles", 64'(bc), 64'd33);
    check("mult_hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.lo_o), 64'hFFFF_FFFA);

    // MULTU with an MTHI attempted while busy (must be ignored)
    start_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.hi_we_i = 1'b1;
    bus.wdata_i = 32'h0000_DEAD;
    @(negedge clk);
    bus.hi_we_i = 1'b0;
    check("mthi_busy_ignored", 64'(bus.hi_o), 64'hFFFF_FFFF);
    wait_done("multu", lat, bc);
    check("multu_hi", 64'(bus.hi_o), 64'hFFFF_FFFE);
    check("multu_lo", 64'(bus.lo_o), 64'h0000_0001);

    run_op("mult_big", MD_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
    run_op("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_neg2", MD_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_1000_7", MD_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142);
    run_op("divu_big", MD_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);

    // Divide by zero completes at edge T+1
    start_op(MD_DIVU, 32'd100, 32'd0);
    wait_done("divz", lat, bc);
    check("divz_latency", 64'(lat), 64'd1);
    check("divz_hi", 64'(bus.hi_o), 64'd100);
    check("divz_lo", 64'(bus.lo_o), 64'hFFFF_FFFF);
    run_op("div_signed_z", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MTLO then a MULT flushed at cycle 10
    @(negedge clk);
    bus.lo_we_i = 1'b1;
    bus.wdata_i = 32'h0000_1234;
    @(negedge clk);
    bus.lo_we_i = 1'b0;
    check("mtlo", 64'(bus.lo_o), 64'h1234);
    start_op(MD_MULT, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    check("flush_busy_before", 64'(bus.busy_o), 64'd1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy_drop", 64'(bus.busy_o), 64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) nd++;
    end
    check("flush_no_done", 64'(nd), 64'd0);
    check("flush_lo_kept", 64'(bus.lo_o), 64'h1234);

    // Asynchronous reset mid-CALC
    start_op(MD_MULTU, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("amid_rst_busy", 64'(bus.busy_o), 64'd0);
    check("amid_rst_hi", 64'(bus.hi_o), 64'd0);
    check("amid_rst_lo", 64'(bus.lo_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // start together with flush in IDLE is dropped
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.flush_i   = 1'b1;
    bus.op_i      = MD_DIVU;
    bus.rs_data_i = 32'd10;
    bus.rt_data_i = 32'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    check("startflush_busy", 64'(bus.busy_o), 64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) nd++;
    end
    check("startflush_no_done", 64'(nd), 64'd0);
    check("startflush_lo", 64'(bus.lo_o), 64'd0);

    // start together with MTLO: write lands, then result overwrites
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.lo_we_i   = 1'b1;
    bus.wdata_i   = 32'd5;
    bus.op_i      = MD_DIVU;
    bus.rs_data_i = 32'd9;
    bus.rt_data_i = 32'd2;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.lo_we_i = 1'b0;
    check("simul_lo_write", 64'(bus.lo_o), 64'd5);
    check("simul_busy", 64'(bus.busy_o), 64'd1);
    wait_done("simul", lat, bc);
    check("simul_lo", 64'(bus.lo_o), 64'd4);
    check("simul_hi", 64'(bus.hi_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
